// File: rtl/regread_stage_pkg.sv
// regread_stage_pkg: shared widths, control-bundle field offsets and the buffered micro-op type
package regread_stage_pkg;
  localparam int PREG_NUM = 64;
  localparam int PREG_W = $clog2(PREG_NUM);
  localparam int XLEN = 64;
  localparam int CTRL_W = 32;
  localparam int ROB_LOG = 6;
  localparam int SRC_RANGE = XLEN;
  localparam int PREG_RANGE = PREG_W;
  localparam int ROB_SIZE_LOG = ROB_LOG;
  // Field offsets inside the opaque control bundle; this stage only passes it through
  localparam int CTRL_ALU_TYPE = 0;
  localparam int CTRL_MULDIV_TYPE = 5;
  localparam int CTRL_CX_TYPE = 9;
  localparam int CTRL_IS_WORD = 12;
  localparam int CTRL_IS_LOAD = 13;
  localparam int CTRL_IS_STORE = 14;
  localparam int CTRL_LS_SIZE = 15;
  localparam int CTRL_IS_UNSIGNED = 17;
  localparam int CTRL_NEED_TO_WB = 18;
  typedef struct packed {
    logic [SRC_RANGE-1:0] src1;
    logic [SRC_RANGE-1:0] src2;
    logic [PREG_RANGE-1:0] prd;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [CTRL_W-1:0] ctrl;
    logic robidx_flag;
    logic [ROB_SIZE_LOG-1:0] robidx;
  } exe_uop_t;
endpackage

// File: rtl/regread_stage_if.sv
// regread_stage_if: issue, writeback, flush and execute-side signals of the register-read stage
interface regread_stage_if;
  import regread_stage_pkg::*;
  logic issue_valid, issue_ready;
  logic [PREG_W-1:0] issue_prs1, issue_prs2, issue_prd;
  logic issue_src1_is_reg, issue_src2_is_reg;
  logic [XLEN-1:0] issue_pc, issue_imm;
  logic [CTRL_W-1:0] issue_ctrl;
  logic issue_robidx_flag;
  logic [ROB_LOG-1:0] issue_robidx;
  logic writeback0_valid, writeback0_need_to_wb, writeback1_valid, writeback1_need_to_wb;
  logic [PREG_W-1:0] writeback0_prd, writeback1_prd;
  logic [XLEN-1:0] writeback0_data, writeback1_data;
  logic flush_valid;
  logic exe_valid, exe_ready;
  logic [XLEN-1:0] exe_src1, exe_src2, exe_pc, exe_imm;
  logic [PREG_W-1:0] exe_prd;
  logic [CTRL_W-1:0] exe_ctrl;
  logic exe_robidx_flag;
  logic [ROB_LOG-1:0] exe_robidx;
  modport master (
    output issue_valid, issue_prs1, issue_prs2, issue_src1_is_reg, issue_src2_is_reg, issue_prd,
           issue_pc, issue_imm, issue_ctrl, issue_robidx_flag, issue_robidx,
           writeback0_valid, writeback0_need_to_wb, writeback0_prd, writeback0_data,
           writeback1_valid, writeback1_need_to_wb, writeback1_prd, writeback1_data,
           flush_valid, exe_ready,
    input issue_ready, exe_valid, exe_src1, exe_src2, exe_prd, exe_pc, exe_imm, exe_ctrl,
          exe_robidx_flag, exe_robidx
  );
  modport slave (
    input issue_valid, issue_prs1, issue_prs2, issue_src1_is_reg, issue_src2_is_reg, issue_prd,
          issue_pc, issue_imm, issue_ctrl, issue_robidx_flag, issue_robidx,
          writeback0_valid, writeback0_need_to_wb, writeback0_prd, writeback0_data,
          writeback1_valid, writeback1_need_to_wb, writeback1_prd, writeback1_data,
          flush_valid, exe_ready,
    output issue_ready, exe_valid, exe_src1, exe_src2, exe_prd, exe_pc, exe_imm, exe_ctrl,
           exe_robidx_flag, exe_robidx
  );
endinterface

// File: rtl/regread_stage_pregfile.sv
// regread_stage_pregfile: 2R/2W physical register file, preg 0 hardwired to zero; REGREAD_BYPASS_EN adds write-first forwarding
module regread_stage_pregfile
  import regread_stage_pkg::*;
(
  input  logic clock,
  input  logic reset_n,
  input  logic wen0,
  input  logic [PREG_RANGE-1:0] waddr0,
  input  logic [SRC_RANGE-1:0] wdata0,
  input  logic wen1,
  input  logic [PREG_RANGE-1:0] waddr1,
  input  logic [SRC_RANGE-1:0] wdata1,
  input  logic [PREG_RANGE-1:0] raddr0,
  output logic [SRC_RANGE-1:0] rdata0,
  input  logic [PREG_RANGE-1:0] raddr1,
  output logic [SRC_RANGE-1:0] rdata1
);
  logic [SRC_RANGE-1:0] rf [PREG_NUM];
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < PREG_NUM; i++) rf[i] <= '0;
    end else begin
      for (int i = 1; i < PREG_NUM; i++) begin
        if (wen1 && waddr1 == PREG_RANGE'(i)) rf[i] <= wdata1;
        else if (wen0 && waddr0 == PREG_RANGE'(i)) rf[i] <= wdata0;
      end
    end
  end
`ifdef REGREAD_BYPASS_EN
  // Port 1 is checked first so it wins, matching the write priority
  assign rdata0 = (raddr0 != '0 && wen1 && waddr1 == raddr0) ? wdata1 :
                  (raddr0 != '0 && wen0 && waddr0 == raddr0) ? wdata0 : rf[raddr0];
  assign rdata1 = (raddr1 != '0 && wen1 && waddr1 == raddr1) ? wdata1 :
                  (raddr1 != '0 && wen0 && waddr0 == raddr1) ? wdata0 : rf[raddr1];
`else
  assign rdata0 = rf[raddr0];
  assign rdata1 = rf[raddr1];
`endif
endmodule

// File: rtl/regread_stage.sv
// regread_stage: operand read/select with a one-entry valid/ready output buffer; REGREAD_BYPASS_EN enables writeback forwarding
module regread_stage
  import regread_stage_pkg::*;
(
  input logic clock,
  input logic reset_n,
  regread_stage_if.slave bus
);
  logic [SRC_RANGE-1:0] rs1, rs2;
  logic accept, valid;
  exe_uop_t uop;
  regread_stage_pregfile u_pregfile (
    .clock(clock),
    .reset_n(reset_n),
    .wen0(bus.writeback0_valid & bus.writeback0_need_to_wb),
    .waddr0(bus.writeback0_prd),
    .wdata0(bus.writeback0_data),
    .wen1(bus.writeback1_valid & bus.writeback1_need_to_wb),
    .waddr1(bus.writeback1_prd),
    .wdata1(bus.writeback1_data),
    .raddr0(bus.issue_prs1),
    .rdata0(rs1),
    .raddr1(bus.issue_prs2),
    .rdata1(rs2)
  );
  assign bus.issue_ready = ~bus.flush_valid & (~valid | bus.exe_ready);
  assign accept = bus.issue_valid & bus.issue_ready;
  // Data fields hold after exe_valid drops; only the valid bit is cleared
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid <= 1'b0;
      uop <= '0;
    end else begin
      valid <= bus.flush_valid ? 1'b0 : accept ? 1'b1 : bus.exe_ready ? 1'b0 : valid;
      if (accept) uop <= '{
        src1: bus.issue_src1_is_reg ? rs1 : bus.issue_pc,
        src2: bus.issue_src2_is_reg ? rs2 : bus.issue_imm,
        prd: bus.issue_prd,
        pc: bus.issue_pc,
        imm: bus.issue_imm,
        ctrl: bus.issue_ctrl,
        robidx_flag: bus.issue_robidx_flag,
        robidx: bus.issue_robidx
      };
    end
  end
  assign bus.exe_valid = valid;
  assign bus.exe_src1 = uop.src1;
  assign bus.exe_src2 = uop.src2;
  assign bus.exe_prd = uop.prd;
  assign bus.exe_pc = uop.pc;
  assign bus.exe_imm = uop.imm;
  assign bus.exe_ctrl = uop.ctrl;
  assign bus.exe_robidx_flag = uop.robidx_flag;
  assign bus.exe_robidx = uop.robidx;
endmodule

// File: doc/regread_stage.md
Name: regread_stage

Overview:
- Sits directly downstream of the integer issue queue and upstream of the execute units.
- Accepts one issued micro-op per cycle and reads its source operands from the physical register file, which lives in a sub-module.
- Selects register, PC or immediate operands, then registers the result into a single-entry output buffer with a valid/ready handshake towards execute.
- Writeback ports 0/1 also write the physical register file through this block.

Parameters:
- PREG_NUM, 64, number of physical registers; PREG_W = $clog2(PREG_NUM).
- XLEN, 64, data/operand width.
- CTRL_W, 32, width of opaque execute-control bundle (alu/muldiv/cx type, is_word, load/store, ls_size, unsigned, need_to_wb), passed through unmodified.
- ROB_LOG, 6, ROB index width.

Ports:
- clock  in  1  core clock.
- reset_n  in  1  asynchronous active-low reset.
- issue_valid  in  1  issued micro-op valid.
- issue_ready  out  1  stage can accept this cycle.
- issue_prs1, issue_prs2  in  PREG_W  physical sources.
- issue_src1_is_reg, issue_src2_is_reg  in  1  source uses register (else PC / imm).
- issue_prd  in  PREG_W  destination preg.
- issue_pc  in  XLEN  PC.
- issue_imm  in  XLEN  immediate.
- issue_ctrl  in  CTRL_W  control bundle.
- issue_robidx_flag  in  1  ROB wrap flag.
- issue_robidx  in  ROB_LOG  ROB index.
- writeback0_valid, writeback0_need_to_wb  in  1  write enable qualifiers.
- writeback0_prd  in  PREG_W  write address.
- writeback0_data  in  XLEN  write data.
- writeback1_valid, writeback1_need_to_wb, writeback1_prd, writeback1_data  same as port 0.
- flush_valid  in  1  pipeline flush (redirect).
- exe_valid  out  1  operands valid.
- exe_ready  in  1  execute accepts.
- exe_src1, exe_src2  out  XLEN  resolved operands.
- exe_prd  out  PREG_W  destination.
- exe_pc  out  XLEN  PC.
- exe_imm  out  XLEN  immediate.
- exe_ctrl  out  CTRL_W  control.
- exe_robidx_flag  out  1  ROB flag.
- exe_robidx  out  ROB_LOG  ROB index.

Behaviour:
- Reset is asynchronous on negedge reset_n. Reset values:
  - exe_valid = 0 and all exe_* data outputs = 0.
  - All register-file entries = 0.
- Handshakes:
  - issue_ready = ~flush_valid & (~exe_valid | exe_ready).
  - Accept when issue_valid & issue_ready.
  - Output transfer when exe_valid & exe_ready.
- Latency is 1 cycle. The register file is read combinationally in the accept cycle, and exe_* is registered at the next posedge.
- Operand select:
  - exe_src1 = src1_is_reg ? RF[prs1] : issue_pc.
  - exe_src2 = src2_is_reg ? RF[prs2] : issue_imm.
- Preg 0 reads as 0 and ignores writes.
- Register-file writes:
  - Port n writes on writebackn_valid & writebackn_need_to_wb, at posedge.
  - Both ports writing the same preg: port 1 wins.
  - Default read is read-before-write, i.e. a same-cycle write is not visible. This is correct without bypass because the issue queue wakes up on writeback and issues no earlier than the next cycle.
- Output register updates:
  - Accept: load the new micro-op, exe_valid = 1. Accept and transfer in the same cycle is back-to-back full throughput.
  - Transfer without accept: exe_valid = 0, data holds.
  - exe_valid & ~exe_ready: hold all outputs stable, issue_ready = 0.
- Flush (flush_valid = 1):
  - exe_valid = 0 next cycle regardless of exe_ready.
  - No accept that cycle.
  - Register-file writes still occur.
- Data outputs are not cleared when exe_valid falls.

Optional Feature:
- Macro: REGREAD_BYPASS_EN.
- Defined: write-first forwarding. If a qualified writeback targets a non-zero preg equal to the prs being read in the accept cycle, the operand takes writeback data. Port 1 has priority over port 0, and forwarding applies only when src_is_reg.
- Undefined: no forwarding muxes; read-before-write as above.

Decomposition:
- Shared constants in defines.sv:
  - Operand, preg and ROB widths: SRC_RANGE, PREG_RANGE, ROB_SIZE_LOG.
  - CTRL bundle field offsets.
- One sub-module, pregfile:
  - PREG_NUM x XLEN storage.
  - 2 asynchronous read ports, 2 synchronous write ports.
  - Preg 0 hardwired to zero, port-1 write priority.
  - Optional bypass mux inside, under REGREAD_BYPASS_EN.

Test Plan:
1. Write preg 5 = 0xDEAD via writeback0; next cycle issue prs1 = 5, src1_is_reg = 1, src2_is_reg = 0, imm = 0x10 -> one cycle later exe_valid = 1, src1 = 0xDEAD, src2 = 0x10.
2. exe_ready = 0 with one micro-op held -> issue_ready = 0 and exe_* stable for 5 cycles; raising exe_ready with a new issue gives back-to-back transfer with no bubble.
3. Issue prs1 = 0, and separately write preg 0 = 0x1234 -> exe_src1 = 0.
4. writeback0 and writeback1 both write preg 9 with 0x1 and 0x2 -> subsequent read returns 0x2.
5. flush_valid while exe_valid = 1 and exe_ready = 0, with issue_valid high -> exe_valid = 0 next cycle and the issue is not accepted.
6. Same-cycle writeback to preg 7 = 0xBEEF while issuing prs2 = 7 -> exe_src2 = 0xBEEF with REGREAD_BYPASS_EN, old value without it. Also assert reset_n low mid-stall -> exe_valid = 0 immediately.
